// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C codec-control blocks (i2c_recv and
// the matching i2c_send initiator).
//   - receive FSM state encoding
//   - default codec device address
//   - register address / register data field widths
//   - helper that builds the first byte of a transfer from address and R/W bit
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 9;

    localparam logic [6:0] I2C_DEV_ADDR = 7'b0011010;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ACK_A     = 4'd2,
        S_BYTE1     = 4'd3,
        S_ACK_1     = 4'd4,
        S_BYTE2     = 4'd5,
        S_ACK_2     = 4'd6,
        S_WAIT_STOP = 4'd7,
        S_IGNORE    = 4'd8
    } i2c_state_e;

    // First byte on the wire: 7-bit device address followed by R/W (1 = read).
    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
        return {dev, rw};
    endfunction

endpackage

// File: rtl/i2c_line_sampler.sv
// i2c_line_sampler: brings SCL/SDA into the clk_12 domain and decodes bus
// events from consecutive samples.
//   i_clk, i_rst_n  : system clock, asynchronous active-low reset
//   i_scl, i_sda    : raw bus lines
//   o_sda           : sampled SDA (value to shift on an SCL rise)
//   o_scl_rise/fall : SCL edge seen between previous and current sample
//   o_start/o_stop  : START / STOP condition (SDA edge while SCL high)
// The synchroniser and "previous" flops reset to 1 (idle bus) so that no
// edge or bus condition is decoded straight out of reset.
module i2c_line_sampler #(
    parameter int SYNC_STAGES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl_cur;
    logic                   w_sda_cur;

    generate
        if (SYNC_STAGES > 1) begin : g_multi
            // Multi-stage synchroniser chain for both bus lines.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_scl_sync <= '1;
                    r_sda_sync <= '1;
                end else begin
                    r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
                    r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
                end
            end
        end else begin : g_single
            // Single sampling flop per line (initiator shares clk_12).
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_scl_sync <= '1;
                    r_sda_sync <= '1;
                end else begin
                    r_scl_sync <= i_scl;
                    r_sda_sync <= i_sda;
                end
            end
        end
    endgenerate

    assign w_scl_cur = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_cur = r_sda_sync[SYNC_STAGES-1];

    // Previous-sample flops used for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl_cur;
            r_sda_prev <= w_sda_cur;
        end
    end

    assign o_sda      = w_sda_cur;
    assign o_scl_rise = ~r_scl_prev & w_scl_cur;
    assign o_scl_fall = r_scl_prev & ~w_scl_cur;
    // SCL must be high in both samples so a data change around an SCL edge
    // is never mistaken for a bus condition.
    assign o_start    = r_scl_prev & w_scl_cur & r_sda_prev & ~w_sda_cur;
    assign o_stop     = r_scl_prev & w_scl_cur & ~r_sda_prev & w_sda_cur;

endmodule

// File: rtl/i2c_recv.sv
// i2c_recv: write-only I2C target for the 2-byte codec register protocol.
// Transfer: START, {DEV_ADDR, W}, {reg_addr[6:0], reg_data[8]},
// reg_data[7:0], STOP; every byte is acknowledged by pulling SDA low.
//   clk_12      : system clock
//   reset_n     : asynchronous active-low reset
//   sclk        : I2C clock from the initiator
//   sdat        : I2C data; only ever driven low or released
//   wr_valid    : one-cycle strobe, complete write received
//   wr_addr     : register address of the last write (held)
//   wr_data     : register data of the last write (held)
//   busy        : transfer in progress (START seen, not yet back to idle)
//   addr_nack   : one-cycle pulse, address byte not acknowledged
//   frame_error : one-cycle pulse, START/STOP at an illegal point
module i2c_recv
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR,
    parameter int         SYNC_STAGES = 1
) (
    input  logic              clk_12,
    input  logic              reset_n,
    input  logic              sclk,
    inout  wire               sdat,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              addr_nack,
    output logic              frame_error
);

    // Sampled bus events
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    // FSM and datapath state
    i2c_state_e r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte1;
    logic       r_ack_drive;
    logic       r_ack_hi;

    // Registered outputs
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_busy;
    logic              r_addr_nack;
    logic              r_frame_error;

    // Next-state values
    i2c_state_e w_state_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] w_shift_nxt;
    logic [7:0] w_byte1_nxt;
    logic       w_ack_drive_nxt;
    logic       w_ack_hi_nxt;
    logic       w_wr_load;
    logic       w_nack_nxt;
    logic       w_ferr_nxt;

    logic [7:0] w_byte_full;
    logic       w_sda_drive;

    i2c_line_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .i_clk      (clk_12),
        .i_rst_n    (reset_n),
        .i_scl      (sclk),
        .i_sda      (sdat),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    // Byte as it stands once the bit on the current SCL rise is shifted in.
    assign w_byte_full = {r_shift[6:0], w_sda};

    // Once the initiator has seen the ACK bit (ack_hi) we let go of SDA as
    // soon as the raw SCL drops, rather than waiting for the sampled fall,
    // so the initiator can put its next bit on SDA without contention.
    assign w_sda_drive = r_ack_drive & ~(r_ack_hi & ~sclk);
    assign sdat        = w_sda_drive ? 1'b0 : 1'bz;

    // Next-state, shift/count and pulse decode for the receive FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_byte1_nxt     = r_byte1;
        w_ack_drive_nxt = r_ack_drive;
        w_ack_hi_nxt    = r_ack_hi;
        w_wr_load       = 1'b0;
        w_nack_nxt      = 1'b0;
        w_ferr_nxt      = 1'b0;

        if (w_start) begin
            // START (or repeated START) always restarts address reception.
            // It is only a framing fault if it cuts into an accepted byte.
            if ((r_state == S_IDLE) || (r_state == S_WAIT_STOP) || (r_state == S_IGNORE)) begin
                w_ferr_nxt = 1'b0;
            end else begin
                w_ferr_nxt = 1'b1;
            end
            w_state_nxt     = S_ADDR;
            w_bit_cnt_nxt   = 3'd0;
            w_shift_nxt     = 8'h00;
            w_ack_drive_nxt = 1'b0;
            w_ack_hi_nxt    = 1'b0;
        end else if (w_stop) begin
            case (r_state)
                S_IDLE, S_IGNORE: w_ferr_nxt = 1'b0;
                S_WAIT_STOP:      w_wr_load  = 1'b1;
                default:          w_ferr_nxt = 1'b1;
            endcase
            w_state_nxt     = S_IDLE;
            w_bit_cnt_nxt   = 3'd0;
            w_ack_drive_nxt = 1'b0;
            w_ack_hi_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_BYTE1, S_BYTE2: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte_full;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            case (r_state)
                                S_ADDR: begin
                                    // A read request is treated like a foreign address.
                                    if (w_byte_full == addr_byte(DEV_ADDR, 1'b0)) begin
                                        w_state_nxt = S_ACK_A;
                                    end else begin
                                        w_nack_nxt  = 1'b1;
                                        w_state_nxt = S_IGNORE;
                                    end
                                end
                                S_BYTE1: begin
                                    w_byte1_nxt = w_byte_full;
                                    w_state_nxt = S_ACK_1;
                                end
                                default: begin
                                    w_state_nxt = S_ACK_2;
                                end
                            endcase
                        end else begin
                            w_state_nxt = r_state;
                        end
                    end else begin
                        w_shift_nxt = r_shift;
                    end
                end
                S_ACK_A, S_ACK_1, S_ACK_2: begin
                    // ACK slot: fall -> drive, rise -> ack_hi, fall -> done.
                    if (w_scl_fall && r_ack_hi) begin
                        w_ack_drive_nxt = 1'b0;
                        w_ack_hi_nxt    = 1'b0;
                        case (r_state)
                            S_ACK_A: w_state_nxt = S_BYTE1;
                            S_ACK_1: w_state_nxt = S_BYTE2;
                            default: w_state_nxt = S_WAIT_STOP;
                        endcase
                    end else if (w_scl_fall) begin
                        w_ack_drive_nxt = 1'b1;
                    end else if (w_scl_rise && r_ack_drive) begin
                        w_ack_hi_nxt = 1'b1;
                    end else begin
                        w_ack_drive_nxt = r_ack_drive;
                    end
                end
                S_WAIT_STOP: begin
                    // The STOP setup raises SCL once; SCL falling again means
                    // the initiator is clocking a third data byte.
                    if (w_scl_fall) begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_IGNORE;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_IDLE, S_IGNORE: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // FSM state, bit counter, shift register and ACK control registers.
    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_byte1     <= 8'h00;
            r_ack_drive <= 1'b0;
            r_ack_hi    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_byte1     <= w_byte1_nxt;
            r_ack_drive <= w_ack_drive_nxt;
            r_ack_hi    <= w_ack_hi_nxt;
        end
    end

    // Output registers: strobes, status and the held write word.
    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_valid    <= 1'b0;
            r_wr_addr     <= 7'd0;
            r_wr_data     <= 9'd0;
            r_busy        <= 1'b0;
            r_addr_nack   <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_wr_valid    <= w_wr_load;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_addr_nack   <= w_nack_nxt;
            r_frame_error <= w_ferr_nxt;
            // The shift register still holds byte 2: nothing shifts after it.
            if (w_wr_load) begin
                r_wr_addr <= r_byte1[7:1];
                r_wr_data <= {r_byte1[0], r_shift};
            end else begin
                r_wr_addr <= r_wr_addr;
                r_wr_data <= r_wr_data;
            end
        end
    end

    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign busy        = r_busy;
    assign addr_nack   = r_addr_nack;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_i2c_recv.sv
// tb_i2c_recv: bit-banged I2C initiator driving two i2c_recv targets that
// share SCL and SDA stimulus; dut_a samples with one flop, dut_b with two.
// Each target has its own SDA net (pulled up) so the ACK of each can be
// observed separately. Expected writes go to per-target queues and are
// popped when wr_valid strobes.
`timescale 1ns/1ps
module tb_i2c_recv;
    import i2c_pkg::*;

    localparam logic [6:0] DEV = 7'b0011010;
    localparam int         NV  = 11;

    typedef struct {
        logic [6:0] dev;
        logic       rw;
        logic [6:0] addr;
        logic [8:0] data;
        logic       ack;
    } vec_t;

    logic clk_12;
    logic reset_n;
    logic scl_drv;
    logic sda_oe;
    wire  sdat_a;
    wire  sdat_b;

    logic       wr_valid_a, wr_valid_b;
    logic [6:0] wr_addr_a, wr_addr_b;
    logic [8:0] wr_data_a, wr_data_b;
    logic       busy_a, busy_b;
    logic       addr_nack_a, addr_nack_b;
    logic       frame_error_a, frame_error_b;

    int checks = 0;
    int errors = 0;
    int q      = 4;
    int nack_a = 0;
    int nack_b = 0;
    int ferr_a = 0;
    int ferr_b = 0;

    logic [15:0] exp_q_a [$];
    logic [15:0] exp_q_b [$];
    vec_t        tbl [NV];

    initial clk_12 = 1'b0;
    always #5 clk_12 = ~clk_12;

    assign sdat_a = sda_oe ? 1'b0 : 1'bz;
    assign sdat_b = sda_oe ? 1'b0 : 1'bz;
    pullup (sdat_a);
    pullup (sdat_b);

    i2c_recv #(.DEV_ADDR(DEV), .SYNC_STAGES(1)) u_dut_a (
        .clk_12(clk_12), .reset_n(reset_n), .sclk(scl_drv), .sdat(sdat_a),
        .wr_valid(wr_valid_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .addr_nack(addr_nack_a), .frame_error(frame_error_a)
    );

    i2c_recv #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) u_dut_b (
        .clk_12(clk_12), .reset_n(reset_n), .sclk(scl_drv), .sdat(sdat_b),
        .wr_valid(wr_valid_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .addr_nack(addr_nack_b), .frame_error(frame_error_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and pulse counters, sampled on the inactive clock edge.
    always @(negedge clk_12) begin
        if (reset_n === 1'b1) begin
            if (wr_valid_a) begin
                if (exp_q_a.size() == 0) check("unexpected wr_valid_a", {31'd0, wr_valid_a}, 32'd0);
                else check("write word a", {16'd0, wr_addr_a, wr_data_a}, {16'd0, exp_q_a.pop_front()});
            end
            if (wr_valid_b) begin
                if (exp_q_b.size() == 0) check("unexpected wr_valid_b", {31'd0, wr_valid_b}, 32'd0);
                else check("write word b", {16'd0, wr_addr_b, wr_data_b}, {16'd0, exp_q_b.pop_front()});
            end
            if (addr_nack_a)   nack_a++;
            if (addr_nack_b)   nack_b++;
            if (frame_error_a) ferr_a++;
            if (frame_error_b) ferr_b++;
        end
    end

    task automatic wait_q();
        repeat (q) @(posedge clk_12);
        #1;
    endtask

    task automatic bus_start();
        sda_oe = 1'b1;
        wait_q();
        scl_drv = 1'b0;
        wait_q();
    endtask

    task automatic bus_bit(input logic b);
        sda_oe = ~b;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        wait_q();
        scl_drv = 1'b0;
        wait_q();
    endtask

    task automatic bus_ack(output logic ack_a, output logic ack_b);
        sda_oe = 1'b0;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        ack_a = (sdat_a == 1'b0);
        ack_b = (sdat_b == 1'b0);
        wait_q();
        scl_drv = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        sda_oe = 1'b1;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        sda_oe = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic bus_rstart();
        sda_oe = 1'b0;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        sda_oe = 1'b1;
        wait_q();
        scl_drv = 1'b0;
        wait_q();
    endtask

    task automatic send_bits(input logic [7:0] v);
        logic [7:0] sh;
        sh = v;
        for (int i = 0; i < 8; i++) begin
            bus_bit(sh[7]);
            sh = {sh[6:0], 1'b0};
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic exp_ack, input string nm);
        logic aa;
        logic ab;
        send_bits(v);
        bus_ack(aa, ab);
        check({nm, " ack a"}, {31'd0, aa}, {31'd0, exp_ack});
        check({nm, " ack b"}, {31'd0, ab}, {31'd0, exp_ack});
    endtask

    task automatic settle();
        repeat (8) @(posedge clk_12);
        #1;
    endtask

    task automatic chk_rst(input string tag);
        check({tag, " wr_valid"},    {31'd0, wr_valid_a},    32'd0);
        check({tag, " wr_addr"},     {25'd0, wr_addr_a},     32'd0);
        check({tag, " wr_data"},     {23'd0, wr_data_a},     32'd0);
        check({tag, " busy"},        {31'd0, busy_a},        32'd0);
        check({tag, " addr_nack"},   {31'd0, addr_nack_a},   32'd0);
        check({tag, " frame_error"}, {31'd0, frame_error_a}, 32'd0);
        check({tag, " sdat a"},      {31'd0, sdat_a},        32'd1);
        check({tag, " sdat b"},      {31'd0, sdat_b},        32'd1);
        check({tag, " wr_addr b"},   {25'd0, wr_addr_b},     32'd0);
        check({tag, " busy b"},      {31'd0, busy_b},        32'd0);
    endtask

    task automatic do_write(input logic [6:0] dev, input logic rw, input logic [6:0] addr,
                            input logic [8:0] data, input logic ack, input string tag);
        int n0a = nack_a;
        int n0b = nack_b;
        int f0a = ferr_a;
        int f0b = ferr_b;
        bus_start();
        check({tag, " busy after START"}, {31'd0, busy_a}, 32'd1);
        send_byte({dev, rw}, ack, {tag, " addr"});
        send_byte({addr, data[8]}, ack, {tag, " byte1"});
        send_byte(data[7:0], ack, {tag, " byte2"});
        if (ack) begin
            exp_q_a.push_back({addr, data});
            exp_q_b.push_back({addr, data});
        end
        bus_stop();
        settle();
        check({tag, " addr_nack a"}, nack_a - n0a, ack ? 32'd0 : 32'd1);
        check({tag, " addr_nack b"}, nack_b - n0b, ack ? 32'd0 : 32'd1);
        check({tag, " frame_error a"}, ferr_a - f0a, 32'd0);
        check({tag, " frame_error b"}, ferr_b - f0b, 32'd0);
        check({tag, " busy a idle"}, {31'd0, busy_a}, 32'd0);
        check({tag, " busy b idle"}, {31'd0, busy_b}, 32'd0);
        check({tag, " pending a"}, exp_q_a.size(), 32'd0);
        check({tag, " pending b"}, exp_q_b.size(), 32'd0);
    endtask

    // Watchdog: the whole run is a few hundred microseconds.
    initial begin
        #3000000;
        $display("FAIL watchdog: run did not reach the summary (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] last_a;
        logic [8:0] last_d;
        int f0a;
        int f0b;

        tbl[0]  = '{DEV,        1'b0, 7'h06, 9'h067, 1'b1};
        tbl[1]  = '{DEV,        1'b0, 7'h0F, 9'h000, 1'b1};
        tbl[2]  = '{DEV,        1'b0, 7'h00, 9'h017, 1'b1};
        tbl[3]  = '{DEV,        1'b0, 7'h01, 9'h017, 1'b1};
        tbl[4]  = '{DEV,        1'b0, 7'h04, 9'h012, 1'b1};
        tbl[5]  = '{DEV,        1'b0, 7'h05, 9'h000, 1'b1};
        tbl[6]  = '{DEV,        1'b0, 7'h06, 9'h000, 1'b1};
        tbl[7]  = '{DEV,        1'b0, 7'h07, 9'h00A, 1'b1};
        tbl[8]  = '{DEV,        1'b0, 7'h09, 9'h001, 1'b1};
        tbl[9]  = '{7'b0011011, 1'b0, 7'h12, 9'h1FF, 1'b0};
        tbl[10] = '{DEV,        1'b1, 7'h13, 9'h0AA, 1'b0};
        last_a = 7'd0;
        last_d = 9'd0;

        reset_n = 1'b0;
        scl_drv = 1'b1;
        sda_oe  = 1'b0;
        repeat (4) @(posedge clk_12);
        #1;
        chk_rst("in reset");
        reset_n = 1'b1;
        repeat (4) @(posedge clk_12);
        #1;
        chk_rst("after reset");

        // Table: spec word, codec init sequence, foreign address, read request.
        for (int k = 0; k < NV; k++) begin
            do_write(tbl[k].dev, tbl[k].rw, tbl[k].addr, tbl[k].data, tbl[k].ack, $sformatf("vec%0d", k));
            if (tbl[k].ack) begin
                last_a = tbl[k].addr;
                last_d = tbl[k].data;
            end
        end

        // STOP right after the byte-1 ACK: abort, fields untouched.
        f0a = ferr_a;
        f0b = ferr_b;
        bus_start();
        send_byte({DEV, 1'b0}, 1'b1, "early stop addr");
        send_byte({7'h11, 1'b1}, 1'b1, "early stop byte1");
        bus_stop();
        settle();
        check("early stop frame_error a", ferr_a - f0a, 32'd1);
        check("early stop frame_error b", ferr_b - f0b, 32'd1);
        check("early stop wr_addr held", {25'd0, wr_addr_a}, {25'd0, last_a});
        check("early stop wr_data held", {23'd0, wr_data_a}, {23'd0, last_d});
        check("early stop busy", {31'd0, busy_a}, 32'd0);
        do_write(DEV, 1'b0, 7'h15, 9'h1AA, 1'b1, "after early stop");

        // Repeated START four bits into byte 2, then a full write to 0x07.
        f0a = ferr_a;
        f0b = ferr_b;
        bus_start();
        send_byte({DEV, 1'b0}, 1'b1, "rstart addr");
        send_byte({7'h22, 1'b0}, 1'b1, "rstart byte1");
        bus_bit(1'b1);
        bus_bit(1'b0);
        bus_bit(1'b1);
        bus_bit(1'b1);
        bus_rstart();
        send_byte({DEV, 1'b0}, 1'b1, "rstart readdr");
        send_byte({7'h07, 1'b0}, 1'b1, "rstart rebyte1");
        send_byte(8'h03, 1'b1, "rstart rebyte2");
        exp_q_a.push_back({7'h07, 9'h003});
        exp_q_b.push_back({7'h07, 9'h003});
        bus_stop();
        settle();
        check("rstart frame_error a", ferr_a - f0a, 32'd1);
        check("rstart frame_error b", ferr_b - f0b, 32'd1);
        check("rstart pending a", exp_q_a.size(), 32'd0);
        check("rstart wr_addr", {25'd0, wr_addr_a}, 32'h07);
        check("rstart wr_data", {23'd0, wr_data_a}, 32'h003);

        // Asynchronous reset while the targets hold the address ACK.
        bus_start();
        send_bits({DEV, 1'b0});
        sda_oe = 1'b0;
        wait_q();
        check("ack drive low a", {31'd0, sdat_a}, 32'd0);
        check("ack drive low b", {31'd0, sdat_b}, 32'd0);
        scl_drv = 1'b1;
        wait_q();
        check("ack held high-phase a", {31'd0, sdat_a}, 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        chk_rst("async reset");
        repeat (3) @(posedge clk_12);
        #1;
        reset_n = 1'b1;
        settle();
        check("post reset busy", {31'd0, busy_a}, 32'd0);
        do_write(DEV, 1'b0, 7'h2A, 9'h0F0, 1'b1, "post reset write");

        // Initiator four times slower.
        q = 16;
        do_write(DEV, 1'b0, 7'h06, 9'h067, 1'b1, "slow");
        q = 4;
        check("slow wr_addr b", {25'd0, wr_addr_b}, 32'h06);
        check("slow wr_data b", {23'd0, wr_data_b}, 32'h067);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
